// File: rtl/serial_out_uart_tx.sv
// Buffers 32-bit words strobed out of the core and sends each one as four
// 8N1 UART bytes, most significant byte first, on a single idle-high line.
module serial_out_uart_tx #(
    parameter int WORD_LENGTH = 32,
    parameter int BAUD_DIV    = 434,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_BITS    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   SerialOutEn,
    input  logic [WORD_LENGTH-1:0] SerialData,
    output logic                   tx,
    output logic                   busy,
    output logic                   overflow,
    output logic [CNT_BITS-1:0]    fifo_count
);

    localparam int PTR_BITS  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BAUD_BITS = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_BITS-1:0]  FULL_CNT  = CNT_BITS'(FIFO_DEPTH);
    localparam logic [BAUD_BITS-1:0] BAUD_LAST = BAUD_BITS'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [BAUD_BITS-1:0]   baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [1:0]             byte_q, byte_d;
    logic [WORD_LENGTH-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;

    logic                   en_prev_q;
    logic [PTR_BITS-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_BITS-1:0]    count_q;
    logic                   overflow_q;
    logic [WORD_LENGTH-1:0] mem [FIFO_DEPTH];

    logic                   push, pop, full, accept, baud_end;
    logic [7:0]             cur_byte;
    logic [2:0]             bit_inc;
    logic [WORD_LENGTH-1:0] head;

    assign push     = SerialOutEn & ~en_prev_q;
    assign full     = (count_q == FULL_CNT);
    // A full FIFO still accepts a word on the cycle the FSM drains one.
    assign accept   = push & (~full | pop);
    assign head     = mem[rd_ptr_q];
    assign baud_end = (baud_q == BAUD_LAST);
    assign cur_byte = shift_q[WORD_LENGTH-1 -: 8];
    assign bit_inc  = bit_q + 3'd1;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= SerialData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_prev_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            en_prev_q <= SerialOutEn;
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CNT_BITS'(1);
                2'b01:   count_q <= count_q - CNT_BITS'(1);
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d always carries the level of the period being entered, so the
    // line flop changes exactly on the state/bit transitions.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    byte_d  = 2'd0;
                    baud_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + BAUD_BITS'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_inc;
                        tx_d  = cur_byte[bit_inc];
                    end
                end else begin
                    baud_d = baud_q + BAUD_BITS'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        shift_d = shift_q << 8;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        byte_d  = 2'd0;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_serial_out_uart_tx.sv
// Directed bench for serial_out_uart_tx with a 4-cycle bit period; frames
// are sampled at the first and last cycle of every bit.
module tb_serial_out_uart_tx;

    localparam int B = 4;

    logic        clk;
    logic        reset;
    logic        SerialOutEn;
    logic [31:0] SerialData;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    serial_out_uart_tx #(
        .WORD_LENGTH(32),
        .BAUD_DIV   (B),
        .FIFO_DEPTH (4),
        .CNT_BITS   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .SerialOutEn(SerialOutEn),
        .SerialData (SerialData),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        SerialOutEn = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic strobe(input logic [31:0] w);
        SerialData  = w;
        SerialOutEn = 1'b1;
        tick();
        SerialOutEn = 1'b0;
        tick();
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        if (tx !== 1'b0) begin
            check({tag, "_start_timeout"}, 32'(n), 32'd0);
        end
    endtask

    task automatic rx_frame(input string tag, input logic [7:0] exp_byte);
        logic [9:0] lo;
        logic [9:0] hi;
        logic [9:0] exp;
        exp = {1'b1, exp_byte, 1'b0};
        lo  = '0;
        hi  = '0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < B; c++) begin
                if (c == 0)     lo[k] = tx;
                if (c == B - 1) hi[k] = tx;
                tick();
            end
        end
        check({tag, "_head"}, 32'(lo), 32'(exp));
        check({tag, "_tail"}, 32'(hi), 32'(exp));
    endtask

    task automatic recv_word(input string tag, input logic [31:0] w, input bit b2b);
        for (int b = 0; b < 4; b++) begin
            if (b == 0 && !b2b) begin
                wait_start(tag);
            end else begin
                check({tag, "_nogap"}, 32'(tx), 32'd0);
            end
            rx_frame($sformatf("%s_b%0d", tag, b), w[31 - 8*b -: 8]);
        end
        $display("rx word 0x%08h (%s)", w, tag);
    endtask

    initial begin
        logic [31:0] words4 [6];
        int t0;
        int peak;
        int lows;

        reset       = 1'b1;
        SerialOutEn = 1'b0;
        SerialData  = 32'h0;
        #2 reset = 1'b0;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_cnt", 32'(fifo_count), 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // 1: single word, latency and total duration
        tick();
        SerialData  = 32'h12345678;
        SerialOutEn = 1'b1;
        tick();
        SerialOutEn = 1'b0;
        SerialData  = 32'hDEADBEEF;
        check("t1_tx_after_push", 32'(tx), 32'd1);
        check("t1_cnt_after_push", 32'(fifo_count), 32'd1);
        check("t1_busy_after_push", 32'(busy), 32'd1);
        tick();
        check("t1_tx_after_pop", 32'(tx), 32'd0);
        check("t1_cnt_after_pop", 32'(fifo_count), 32'd0);
        t0 = cyc;
        recv_word("t1", 32'h12345678, 1'b1);
        check("t1_cycles", 32'(cyc - t0), 32'd160);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_tx_end", 32'(tx), 32'd1);

        // 2: level held high pushes one word
        peak = 0;
        fork
            begin
                SerialData  = 32'hAABBCCDD;
                SerialOutEn = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    tick();
                    if (int'(fifo_count) > peak) peak = int'(fifo_count);
                end
                SerialOutEn = 1'b0;
            end
            recv_word("t2", 32'hAABBCCDD, 1'b0);
        join
        check("t2_peak", 32'(peak), 32'd1);
        check("t2_busy_end", 32'(busy), 32'd0);
        lows = 0;
        for (int i = 0; i < 10 * B; i++) begin
            tick();
            if (tx === 1'b0) lows++;
        end
        check("t2_single_word", 32'(lows), 32'd0);

        // 3: six strobes, sixth dropped, five sent back to back
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    strobe(32'(i));
                    if (i == 5) begin
                        check("t3_cnt_full", 32'(fifo_count), 32'd4);
                        check("t3_ovf_before", 32'(overflow), 32'd0);
                    end
                end
                check("t3_ovf_set", 32'(overflow), 32'd1);
                check("t3_cnt_after_drop", 32'(fifo_count), 32'd4);
            end
            begin
                for (int i = 1; i <= 5; i++) begin
                    recv_word($sformatf("t3_w%0d", i), 32'(i), i != 1);
                end
            end
        join
        check("t3_busy_end", 32'(busy), 32'd0);
        check("t3_tx_end", 32'(tx), 32'd1);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: push on the same edge as the pop while full
        do_reset();
        check("t4_ovf_cleared", 32'(overflow), 32'd0);
        words4[0] = 32'hA5A50F0F;
        words4[1] = 32'hC33C817E;
        words4[2] = 32'h01234567;
        words4[3] = 32'h89ABCDEF;
        words4[4] = 32'h5A5AA5A5;
        words4[5] = 32'hF00DCAFE;
        fork
            begin
                for (int i = 0; i < 5; i++) strobe(words4[i]);
                repeat (151) tick();
                check("t4_cnt_before", 32'(fifo_count), 32'd4);
                SerialData  = words4[5];
                SerialOutEn = 1'b1;
                tick();
                SerialOutEn = 1'b0;
                check("t4_cnt_same_edge", 32'(fifo_count), 32'd4);
                check("t4_ovf_same_edge", 32'(overflow), 32'd0);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    recv_word($sformatf("t4_w%0d", i), words4[i], i != 0);
                end
            end
        join
        check("t4_ovf_end", 32'(overflow), 32'd0);
        check("t4_busy_end", 32'(busy), 32'd0);

        // 5: asynchronous reset during the data bits
        do_reset();
        strobe(32'hFFFFFFFF);
        for (int i = 1; i <= 5; i++) strobe(32'(i));
        check("t5_ovf_pre", 32'(overflow), 32'd1);
        check("t5_cnt_pre", 32'(fifo_count), 32'd4);
        #2;
        reset = 1'b0;
        #1;
        check("t5_tx_async", 32'(tx), 32'd1);
        check("t5_busy_async", 32'(busy), 32'd0);
        check("t5_cnt_async", 32'(fifo_count), 32'd0);
        check("t5_ovf_async", 32'(overflow), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        lows = 0;
        for (int i = 0; i < 20 * B; i++) begin
            tick();
            if (tx === 1'b0) lows++;
        end
        check("t5_idle_after_rst", 32'(lows), 32'd0);
        check("t5_busy_idle", 32'(busy), 32'd0);
        SerialData  = 32'h0F0F0F0F;
        SerialOutEn = 1'b1;
        tick();
        SerialOutEn = 1'b0;
        tick();
        check("t5_restart", 32'(tx), 32'd0);

        // 6: all-zero then all-one words
        do_reset();
        fork
            begin
                strobe(32'h00000000);
                SerialData  = 32'hFFFFFFFF;
                SerialOutEn = 1'b1;
                tick();
                SerialOutEn = 1'b0;
            end
            begin
                wait_start("t6");
                t0 = cyc;
                recv_word("t6_zero", 32'h00000000, 1'b1);
                recv_word("t6_ones", 32'hFFFFFFFF, 1'b1);
                check("t6_cycles", 32'(cyc - t0), 32'd320);
            end
        join
        check("t6_busy_end", 32'(busy), 32'd0);
        check("t6_tx_end", 32'(tx), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
